// File: rtl/bus_pkg.sv
// Shared bus definitions: word width, source indices and arbiter state encoding.
package bus_pkg;

  localparam int unsigned BUS_W = 16;

  localparam int unsigned SRC_PC = 0;
  localparam int unsigned SRC_AR = 1;
  localparam int unsigned SRC_AC = 2;
  localparam int unsigned SRC_R  = 3;
  localparam int unsigned SRC_DM = 4;
  localparam int unsigned SRC_IM = 5;
  localparam int unsigned SRC_DR = 6;

  typedef enum logic {
    IDLE,
    OWNED
  } bus_state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational wrap-around priority picker: first set req bit at or after start wins.
module bus_rr_pick #(
  parameter int unsigned N_SRC = 7,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_SRC-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic int unsigned wrap(input int unsigned a);
    return (a >= N_SRC) ? a - N_SRC : a;
  endfunction

  // Scan from furthest to nearest so the nearest requester is the last write.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[wrap(32'(start) + 32'(k))]) begin
        onehot                          = '0;
        onehot[wrap(32'(start) + 32'(k))] = 1'b1;
        idx                             = IDX_W'(wrap(32'(start) + 32'(k)));
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus mux with fixed-priority / round-robin arbitration and lock.
// Optional contention counter enabled by defining BUS_CONFLICT_CHK_EN.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_W,
  parameter int unsigned N_SRC  = 7,
  parameter bit          RR_EN  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC-1:0]        lock,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        grant,
  output logic [DATA_W-1:0]       bus,
  output logic                    bus_valid,
  output logic [7:0]              conflict_cnt,
  output logic                    conflict_seen
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  bus_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic               valid_q, valid_d;

  logic [N_SRC-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [IDX_W-1:0]   pick_start;
  logic               hold;

  assign pick_start = RR_EN ? rr_ptr_q : '0;
  assign hold       = (state_q == OWNED) && req[owner_q] && lock[owner_q];

  bus_rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // A release cycle falls through to normal arbitration, so there is no bubble.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    bus_d    = bus_q;
    valid_d  = 1'b0;
    if (hold) begin
      bus_d   = src_data[32'(owner_q)*DATA_W +: DATA_W];
      valid_d = 1'b1;
    end else if (win_any) begin
      grant_d = win_oh;
      bus_d   = src_data[32'(win_idx)*DATA_W +: DATA_W];
      valid_d = 1'b1;
      owner_d = win_idx;
      state_d = lock[win_idx] ? OWNED : IDLE;
      if (RR_EN) begin
        rr_ptr_d = (32'(win_idx) == N_SRC - 1) ? '0 : win_idx + 1'b1;
      end
    end else begin
      grant_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
    end
  end

  assign grant     = grant_q;
  assign bus       = bus_q;
  assign bus_valid = valid_q;

`ifdef BUS_CONFLICT_CHK_EN
  logic [7:0] cnt_q;
  logic       seen_q;
  logic       contention;

  assign contention = !hold && ($countones(req) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else if (contention) begin
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      seen_q <= 1'b1;
    end
  end

  assign conflict_cnt  = cnt_q;
  assign conflict_seen = seen_q;
`else
  assign conflict_cnt  = '0;
  assign conflict_seen = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench: fixed-priority and round-robin instances checked against a behavioural model.
module tb_bus_arbiter_mux;

  localparam int DW = 16;
  localparam int NS = 7;

  typedef struct packed {
    logic [NS-1:0] grant;
    logic [DW-1:0] bus;
    logic          valid;
    logic [7:0]    cnt;
    logic          seen;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    req;
  logic [NS-1:0]    lock;
  logic [NS*DW-1:0] src_data;

  logic [NS-1:0] grant_f, grant_r;
  logic [DW-1:0] bus_f, bus_r;
  logic          valid_f, valid_r;
  logic [7:0]    cnt_f, cnt_r;
  logic          seen_f, seen_r;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_exp[2][$];

  // Model state, index 0 = fixed priority, 1 = round-robin.
  logic [NS-1:0] m_grant[2];
  logic [DW-1:0] m_bus[2];
  logic          m_valid[2];
  logic          m_owned[2];
  int            m_owner[2];
  int            m_ptr[2];
  logic [7:0]    m_cnt[2];
  logic          m_seen[2];

  always #5 clk = ~clk;

  bus_arbiter_mux #(.DATA_W(DW), .N_SRC(NS), .RR_EN(1'b0)) u_fix (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .src_data(src_data),
    .grant(grant_f), .bus(bus_f), .bus_valid(valid_f),
    .conflict_cnt(cnt_f), .conflict_seen(seen_f)
  );

  bus_arbiter_mux #(.DATA_W(DW), .N_SRC(NS), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .src_data(src_data),
    .grant(grant_r), .bus(bus_r), .bus_valid(valid_r),
    .conflict_cnt(cnt_r), .conflict_seen(seen_r)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input int i);
    return 16'h1000 + 16'(i);
  endfunction

  task automatic model_update(input int m);
    int start, w, j;
    if (rst) begin
      m_grant[m] = '0; m_bus[m] = '0; m_valid[m] = 1'b0; m_owned[m] = 1'b0;
      m_owner[m] = 0;  m_ptr[m] = 0;  m_cnt[m] = '0;     m_seen[m] = 1'b0;
    end else if (m_owned[m] && req[m_owner[m]] && lock[m_owner[m]]) begin
      m_bus[m]   = src_word(m_owner[m]);
      m_valid[m] = 1'b1;
    end else begin
`ifdef BUS_CONFLICT_CHK_EN
      if ($countones(req) > 1) begin
        if (m_cnt[m] < 8'd255) m_cnt[m] = m_cnt[m] + 8'd1;
        m_seen[m] = 1'b1;
      end
`endif
      m_owned[m] = 1'b0;
      if (req == '0) begin
        m_grant[m] = '0;
        m_valid[m] = 1'b0;
      end else begin
        start = (m == 1) ? m_ptr[m] : 0;
        w = -1;
        for (int k = 0; k < NS; k++) begin
          j = (start + k) % NS;
          if (w < 0 && req[j]) w = j;
        end
        m_grant[m] = '0;
        m_grant[m][w] = 1'b1;
        m_bus[m]   = src_word(w);
        m_valid[m] = 1'b1;
        if (m == 1) m_ptr[m] = (w + 1) % NS;
        if (lock[w]) begin
          m_owned[m] = 1'b1;
          m_owner[m] = w;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [NS-1:0] rq, input logic [NS-1:0] lk);
    exp_t e;
    rst = r; req = rq; lock = lk;
    for (int m = 0; m < 2; m++) begin
      model_update(m);
      q_exp[m].push_back({m_grant[m], m_bus[m], m_valid[m], m_cnt[m], m_seen[m]});
    end
    @(posedge clk);
    #1;
    e = q_exp[0].pop_front();
    check_eq("fix_grant", 32'(grant_f), 32'(e.grant));
    check_eq("fix_bus",   32'(bus_f),   32'(e.bus));
    check_eq("fix_valid", 32'(valid_f), 32'(e.valid));
    check_eq("fix_cnt",   32'(cnt_f),   32'(e.cnt));
    check_eq("fix_seen",  32'(seen_f),  32'(e.seen));
    e = q_exp[1].pop_front();
    check_eq("rr_grant", 32'(grant_r), 32'(e.grant));
    check_eq("rr_bus",   32'(bus_r),   32'(e.bus));
    check_eq("rr_valid", 32'(valid_r), 32'(e.valid));
    check_eq("rr_cnt",   32'(cnt_r),   32'(e.cnt));
    check_eq("rr_seen",  32'(seen_r),  32'(e.seen));
  endtask

  initial begin
    logic [NS-1:0] g;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = src_word(i);
    rst = 1'b1; req = '0; lock = '0;
    #1;

    // Reset with all sources requesting.
    step(1'b1, 7'h7F, 7'h00);
    step(1'b1, 7'h7F, 7'h00);
    check_eq("rst_grant", 32'(grant_f), 32'h0);
    check_eq("rst_bus",   32'(bus_f),   32'h0);
    check_eq("rst_valid", 32'(valid_f), 32'h0);
    check_eq("rst_cnt",   32'(cnt_f),   32'h0);

    // Fixed priority, then idle hold.
    step(1'b0, 7'b0010100, 7'h00);
    check_eq("fp_grant", 32'(grant_f), 32'b0000100);
    check_eq("fp_bus",   32'(bus_f),   32'h1002);
    check_eq("fp_valid", 32'(valid_f), 32'h1);
    step(1'b0, 7'h00, 7'h00);
    check_eq("idle_grant", 32'(grant_f), 32'h0);
    check_eq("idle_bus",   32'(bus_f),   32'h1002);
    check_eq("idle_valid", 32'(valid_f), 32'h0);

    // Round-robin rotation from a fresh pointer.
    step(1'b1, 7'h00, 7'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 7'h7F, 7'h00);
      g = '0;
      g[i % NS] = 1'b1;
      check_eq("rr_rot_grant", 32'(grant_r), 32'(g));
      check_eq("rr_rot_bus",   32'(bus_r),   32'(src_word(i % NS)));
    end

    // Lock held by source 4 against higher-priority source 0; release without bubble.
    step(1'b0, 7'b0010000, 7'b0010000);
    check_eq("lock_acq", 32'(grant_f), 32'b0010000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 7'b0010001, 7'b0010000);
      check_eq("lock_hold", 32'(grant_f), 32'b0010000);
      check_eq("lock_bus",  32'(bus_f),   32'h1004);
    end
    step(1'b0, 7'b0000001, 7'h00);
    check_eq("rel_grant", 32'(grant_f), 32'b0000001);
    check_eq("rel_bus",   32'(bus_f),   32'h1000);
    check_eq("rel_valid", 32'(valid_f), 32'h1);

    // Reset while owned, then re-acquire.
    step(1'b0, 7'b0010000, 7'b0010000);
    step(1'b1, 7'b0010000, 7'b0010000);
    check_eq("rstlock_grant", 32'(grant_f), 32'h0);
    check_eq("rstlock_valid", 32'(valid_f), 32'h0);
    step(1'b0, 7'b0010000, 7'b0010000);
    check_eq("reacq_grant", 32'(grant_f), 32'b0010000);
    check_eq("reacq_valid", 32'(valid_f), 32'h1);

    // Random traffic with sparse locks and occasional reset.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) == 0), NS'($urandom), NS'($urandom & $urandom & $urandom));
    end

    // Saturating contention count.
    step(1'b1, 7'h00, 7'h00);
    for (int i = 0; i < 300; i++) step(1'b0, 7'b0000011, 7'h00);
`ifdef BUS_CONFLICT_CHK_EN
    check_eq("sat_cnt",  32'(cnt_f),  32'd255);
    check_eq("sat_seen", 32'(seen_f), 32'd1);
`else
    check_eq("sat_cnt",  32'(cnt_f),  32'd0);
    check_eq("sat_seen", 32'(seen_f), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
